orientation_histogram_accumulator: RTL and testbench

ORIENTATION_HISTOGRAM_ACCUMULATOR -- requirements
Module: orientation_histogram_accumulator

---
 rtl/orientation_histogram_accumulator_pkg.sv | 20 ++
 rtl/orientation_histogram_accumulator_hist_bin_update.sv | 56 +++++
 rtl/orientation_histogram_accumulator.sv | 164 ++++++++++++++++
 tb/tb_orientation_histogram_accumulator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/orientation_histogram_accumulator_pkg.sv
// Shared constants for the orientation histogram and the downstream
// maximum-orientation stage: bin geometry and FSM state encoding.
package orientation_histogram_accumulator_pkg;

  localparam int          NUM_BINS  = 36;
  localparam int          BIN_W     = 16;
  localparam int          BIN_IDX_W = 6;
  localparam logic [15:0] BIN_MAX   = 16'hFFFF;

  // FSM encoding; IDLE is all-zero so the reset value is the idle state.
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACCUM  = 2'd1;
  localparam logic [1:0]  ST_DONE   = 2'd2;

  // A bin index is usable only inside 0..NUM_BINS-1.
  function automatic logic bin_is_legal(input logic [BIN_IDX_W-1:0] idx);
    return (idx < 6'd36);
  endfunction

endpackage

// File: rtl/orientation_histogram_accumulator_hist_bin_update.sv
// One histogram bin: clear on window start, add the sample weight when the
// sample addresses this bin, saturate or wrap on overflow.
module hist_bin_update
  import orientation_histogram_accumulator_pkg::*;
#(
  parameter int                   MAG_W   = 12,
  parameter int                   SAT_EN  = 1,
  parameter logic [BIN_IDX_W-1:0] BIN_IDX = 6'd0
) (
  input  logic                 iclk,
  input  logic                 ireset,
  input  logic                 iclear,
  input  logic                 iaccept,
  input  logic [BIN_IDX_W-1:0] isample_bin,
  input  logic [MAG_W-1:0]     isample_mag,
  output logic [BIN_W-1:0]     obin
);

  localparam int SUM_W = BIN_W + 1;

  logic             hit_s;
  logic [SUM_W-1:0] sum_s;
  logic [BIN_W-1:0] add_s;
  logic [BIN_W-1:0] bin_d;
  logic [BIN_W-1:0] bin_q;

  // Next bin value: a clear with a same-cycle hit starts from the new weight.
  always_comb begin
    hit_s = iaccept && (isample_bin == BIN_IDX);
    sum_s = {1'b0, bin_q} + SUM_W'(isample_mag);
    if ((SAT_EN != 0) && sum_s[BIN_W]) begin
      add_s = BIN_MAX;
    end else begin
      add_s = sum_s[BIN_W-1:0];
    end
    if (iclear) begin
      bin_d = hit_s ? BIN_W'(isample_mag) : 16'h0000;
    end else if (hit_s) begin
      bin_d = add_s;
    end else begin
      bin_d = bin_q;
    end
  end

  // Bin register.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      bin_q <= 16'h0000;
    end else begin
      bin_q <= bin_d;
    end
  end

  assign obin = bin_q;

endmodule

// File: rtl/orientation_histogram_accumulator.sv
// Keypoint orientation histogram: accumulates weighted samples into 36 bins
// per window and flags completion with a one-cycle odata_en pulse.
module orientation_histogram_accumulator
  import orientation_histogram_accumulator_pkg::*;
#(
  parameter int MAG_W  = 12,
  parameter int SAT_EN = 1
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             istart,
  input  logic             isample_valid,
  input  logic [5:0]       isample_bin,
  input  logic [MAG_W-1:0] isample_mag,
  input  logic             isample_last,
  output logic [15:0]      ostatistics_orientation0,
  output logic [15:0]      ostatistics_orientation1,
  output logic [15:0]      ostatistics_orientation2,
  output logic [15:0]      ostatistics_orientation3,
  output logic [15:0]      ostatistics_orientation4,
  output logic [15:0]      ostatistics_orientation5,
  output logic [15:0]      ostatistics_orientation6,
  output logic [15:0]      ostatistics_orientation7,
  output logic [15:0]      ostatistics_orientation8,
  output logic [15:0]      ostatistics_orientation9,
  output logic [15:0]      ostatistics_orientation10,
  output logic [15:0]      ostatistics_orientation11,
  output logic [15:0]      ostatistics_orientation12,
  output logic [15:0]      ostatistics_orientation13,
  output logic [15:0]      ostatistics_orientation14,
  output logic [15:0]      ostatistics_orientation15,
  output logic [15:0]      ostatistics_orientation16,
  output logic [15:0]      ostatistics_orientation17,
  output logic [15:0]      ostatistics_orientation18,
  output logic [15:0]      ostatistics_orientation19,
  output logic [15:0]      ostatistics_orientation20,
  output logic [15:0]      ostatistics_orientation21,
  output logic [15:0]      ostatistics_orientation22,
  output logic [15:0]      ostatistics_orientation23,
  output logic [15:0]      ostatistics_orientation24,
  output logic [15:0]      ostatistics_orientation25,
  output logic [15:0]      ostatistics_orientation26,
  output logic [15:0]      ostatistics_orientation27,
  output logic [15:0]      ostatistics_orientation28,
  output logic [15:0]      ostatistics_orientation29,
  output logic [15:0]      ostatistics_orientation30,
  output logic [15:0]      ostatistics_orientation31,
  output logic [15:0]      ostatistics_orientation32,
  output logic [15:0]      ostatistics_orientation33,
  output logic [15:0]      ostatistics_orientation34,
  output logic [15:0]      ostatistics_orientation35,
  output logic             odata_en,
  output logic             obusy,
  output logic             obin_error
);

  logic [1:0]       state_d, state_q;
  logic             accept_s;
  logic             data_en_d, data_en_q;
  logic             busy_d, busy_q;
  logic             bin_error_d, bin_error_q;
  logic [BIN_W-1:0] bins_s [NUM_BINS];

  // Sample acceptance, state transitions and registered status outputs.
  // istart takes precedence: it always (re)opens a window.
  always_comb begin
    accept_s = isample_valid && ((state_q == ST_ACCUM) || istart);
    if (istart) begin
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_IDLE;
        ST_ACCUM: state_d = (accept_s && isample_last) ? ST_DONE : ST_ACCUM;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
    if (istart) begin
      bin_error_d = accept_s && !bin_is_legal(isample_bin);
    end else if (accept_s && !bin_is_legal(isample_bin)) begin
      bin_error_d = 1'b1;
    end else begin
      bin_error_d = bin_error_q;
    end
    data_en_d = (state_d == ST_DONE);
    busy_d    = (state_d == ST_ACCUM);
  end

  // Control and status registers.
  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_q     <= ST_IDLE;
      data_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      bin_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_en_q   <= data_en_d;
      busy_q      <= busy_d;
      bin_error_q <= bin_error_d;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_BINS; g++) begin : g_bin
      hist_bin_update #(
        .MAG_W   (MAG_W),
        .SAT_EN  (SAT_EN),
        .BIN_IDX (6'(g))
      ) u_bin (
        .iclk        (iclk),
        .ireset      (ireset),
        .iclear      (istart),
        .iaccept     (accept_s),
        .isample_bin (isample_bin),
        .isample_mag (isample_mag),
        .obin        (bins_s[g])
      );
    end
  endgenerate

  assign odata_en   = data_en_q;
  assign obusy      = busy_q;
  assign obin_error = bin_error_q;

  assign ostatistics_orientation0  = bins_s[0];
  assign ostatistics_orientation1  = bins_s[1];
  assign ostatistics_orientation2  = bins_s[2];
  assign ostatistics_orientation3  = bins_s[3];
  assign ostatistics_orientation4  = bins_s[4];
  assign ostatistics_orientation5  = bins_s[5];
  assign ostatistics_orientation6  = bins_s[6];
  assign ostatistics_orientation7  = bins_s[7];
  assign ostatistics_orientation8  = bins_s[8];
  assign ostatistics_orientation9  = bins_s[9];
  assign ostatistics_orientation10 = bins_s[10];
  assign ostatistics_orientation11 = bins_s[11];
  assign ostatistics_orientation12 = bins_s[12];
  assign ostatistics_orientation13 = bins_s[13];
  assign ostatistics_orientation14 = bins_s[14];
  assign ostatistics_orientation15 = bins_s[15];
  assign ostatistics_orientation16 = bins_s[16];
  assign ostatistics_orientation17 = bins_s[17];
  assign ostatistics_orientation18 = bins_s[18];
  assign ostatistics_orientation19 = bins_s[19];
  assign ostatistics_orientation20 = bins_s[20];
  assign ostatistics_orientation21 = bins_s[21];
  assign ostatistics_orientation22 = bins_s[22];
  assign ostatistics_orientation23 = bins_s[23];
  assign ostatistics_orientation24 = bins_s[24];
  assign ostatistics_orientation25 = bins_s[25];
  assign ostatistics_orientation26 = bins_s[26];
  assign ostatistics_orientation27 = bins_s[27];
  assign ostatistics_orientation28 = bins_s[28];
  assign ostatistics_orientation29 = bins_s[29];
  assign ostatistics_orientation30 = bins_s[30];
  assign ostatistics_orientation31 = bins_s[31];
  assign ostatistics_orientation32 = bins_s[32];
  assign ostatistics_orientation33 = bins_s[33];
  assign ostatistics_orientation34 = bins_s[34];
  assign ostatistics_orientation35 = bins_s[35];

endmodule

// File: tb/tb_orientation_histogram_accumulator.sv
// Bench for orientation_histogram_accumulator: a saturating and a wrapping
// instance share one stimulus stream; a window-level model predicts the bins.
module tb_orientation_histogram_accumulator;

  logic        iclk = 1'b0;
  logic        ireset = 1'b0;
  logic        istart = 1'b0;
  logic        isample_valid = 1'b0;
  logic [5:0]  isample_bin = 6'd0;
  logic [11:0] isample_mag = 12'd0;
  logic        isample_last = 1'b0;

  logic [15:0] bs [36];
  logic [15:0] bw [36];
  logic        den_s, busy_s, err_s, den_w, busy_w, err_w;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit chk_on = 1'b0;

  // Window-level model state.
  int ms [36];
  int mw [36];
  bit m_open = 1'b0;
  bit m_den = 1'b0;
  bit m_err = 1'b0;

  always #5 iclk = ~iclk;

  orientation_histogram_accumulator #(.MAG_W(12), .SAT_EN(1)) u_sat (
    .iclk(iclk), .ireset(ireset), .istart(istart), .isample_valid(isample_valid),
    .isample_bin(isample_bin), .isample_mag(isample_mag), .isample_last(isample_last),
    .ostatistics_orientation0(bs[0]), .ostatistics_orientation1(bs[1]), .ostatistics_orientation2(bs[2]),
    .ostatistics_orientation3(bs[3]), .ostatistics_orientation4(bs[4]), .ostatistics_orientation5(bs[5]),
    .ostatistics_orientation6(bs[6]), .ostatistics_orientation7(bs[7]), .ostatistics_orientation8(bs[8]),
    .ostatistics_orientation9(bs[9]), .ostatistics_orientation10(bs[10]), .ostatistics_orientation11(bs[11]),
    .ostatistics_orientation12(bs[12]), .ostatistics_orientation13(bs[13]), .ostatistics_orientation14(bs[14]),
    .ostatistics_orientation15(bs[15]), .ostatistics_orientation16(bs[16]), .ostatistics_orientation17(bs[17]),
    .ostatistics_orientation18(bs[18]), .ostatistics_orientation19(bs[19]), .ostatistics_orientation20(bs[20]),
    .ostatistics_orientation21(bs[21]), .ostatistics_orientation22(bs[22]), .ostatistics_orientation23(bs[23]),
    .ostatistics_orientation24(bs[24]), .ostatistics_orientation25(bs[25]), .ostatistics_orientation26(bs[26]),
    .ostatistics_orientation27(bs[27]), .ostatistics_orientation28(bs[28]), .ostatistics_orientation29(bs[29]),
    .ostatistics_orientation30(bs[30]), .ostatistics_orientation31(bs[31]), .ostatistics_orientation32(bs[32]),
    .ostatistics_orientation33(bs[33]), .ostatistics_orientation34(bs[34]), .ostatistics_orientation35(bs[35]),
    .odata_en(den_s), .obusy(busy_s), .obin_error(err_s)
  );

  orientation_histogram_accumulator #(.MAG_W(12), .SAT_EN(0)) u_wrap (
    .iclk(iclk), .ireset(ireset), .istart(istart), .isample_valid(isample_valid),
    .isample_bin(isample_bin), .isample_mag(isample_mag), .isample_last(isample_last),
    .ostatistics_orientation0(bw[0]), .ostatistics_orientation1(bw[1]), .ostatistics_orientation2(bw[2]),
    .ostatistics_orientation3(bw[3]), .ostatistics_orientation4(bw[4]), .ostatistics_orientation5(bw[5]),
    .ostatistics_orientation6(bw[6]), .ostatistics_orientation7(bw[7]), .ostatistics_orientation8(bw[8]),
    .ostatistics_orientation9(bw[9]), .ostatistics_orientation10(bw[10]), .ostatistics_orientation11(bw[11]),
    .ostatistics_orientation12(bw[12]), .ostatistics_orientation13(bw[13]), .ostatistics_orientation14(bw[14]),
    .ostatistics_orientation15(bw[15]), .ostatistics_orientation16(bw[16]), .ostatistics_orientation17(bw[17]),
    .ostatistics_orientation18(bw[18]), .ostatistics_orientation19(bw[19]), .ostatistics_orientation20(bw[20]),
    .ostatistics_orientation21(bw[21]), .ostatistics_orientation22(bw[22]), .ostatistics_orientation23(bw[23]),
    .ostatistics_orientation24(bw[24]), .ostatistics_orientation25(bw[25]), .ostatistics_orientation26(bw[26]),
    .ostatistics_orientation27(bw[27]), .ostatistics_orientation28(bw[28]), .ostatistics_orientation29(bw[29]),
    .ostatistics_orientation30(bw[30]), .ostatistics_orientation31(bw[31]), .ostatistics_orientation32(bw[32]),
    .ostatistics_orientation33(bw[33]), .ostatistics_orientation34(bw[34]), .ostatistics_orientation35(bw[35]),
    .odata_en(den_w), .obusy(busy_w), .obin_error(err_w)
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 36; i++) begin
      ms[i] = 0;
      mw[i] = 0;
    end
  endtask

  // One clock of stimulus; the model is advanced right after the edge.
  task automatic step(input bit st, input bit v, input int b, input int mg, input bit l);
    bit acc;
    istart = st;
    isample_valid = v;
    isample_bin = 6'(b);
    isample_mag = 12'(mg);
    isample_last = l;
    @(posedge iclk);
    acc = v && (m_open || st);
    if (st) begin
      model_clear();
      m_err = 1'b0;
    end
    if (acc) begin
      if (b > 35) begin
        m_err = 1'b1;
      end else begin
        ms[b] = (ms[b] + mg > 65535) ? 65535 : ms[b] + mg;
        mw[b] = (mw[b] + mg) % 65536;
      end
    end
    m_den = acc && l && !st;
    m_open = st ? 1'b1 : (m_open && !(acc && l));
    #1;
    istart = 1'b0;
    isample_valid = 1'b0;
    isample_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  // Every cycle: both instances against the model.
  always @(negedge iclk) begin
    if (chk_on) begin
      for (int i = 0; i < 36; i++) begin
        chk($sformatf("sat_bin%0d", i), int'(bs[i]), ms[i]);
        chk($sformatf("wrap_bin%0d", i), int'(bw[i]), mw[i]);
      end
      chk("sat_data_en", int'(den_s), int'(m_den));
      chk("wrap_data_en", int'(den_w), int'(m_den));
      chk("sat_busy", int'(busy_s), int'(m_open));
      chk("wrap_busy", int'(busy_w), int'(m_open));
      chk("sat_bin_error", int'(err_s), int'(m_err));
      chk("wrap_bin_error", int'(err_w), int'(m_err));
    end
  end

  // Count observed completion pulses.
  always @(negedge iclk) begin
    if (den_s) pulses++;
  end

  initial begin
    model_clear();
    repeat (3) @(posedge iclk);
    #1;
    chk("reset_bin5", int'(bs[5]), 0);
    chk("reset_busy", int'(busy_s), 0);
    chk("reset_data_en", int'(den_s), 0);
    chk("reset_err", int'(err_s), 0);
    ireset = 1'b1;
    chk_on = 1'b1;
    idle(2);

    // Basic window: bin5 = 10+20, bin35 = 7.
    pulses = 0;
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 5, 10, 1'b0);
    step(1'b0, 1'b1, 5, 20, 1'b0);
    step(1'b0, 1'b1, 35, 7, 1'b1);
    chk("basic_bin5", int'(bs[5]), 30);
    chk("basic_bin35", int'(bs[35]), 7);
    chk("basic_bin0", int'(bs[0]), 0);
    chk("basic_data_en", int'(den_s), 1);
    chk("model_bin5", ms[5], 30);
    idle(1);
    chk("basic_data_en_drop", int'(den_s), 0);
    idle(2);
    chk("basic_hold_bin5", int'(bs[5]), 30);
    chk("basic_pulses", pulses, 1);

    // 20 x 4095 into bin 0: 81900 saturates, or wraps to 81900-65536.
    step(1'b1, 1'b0, 0, 0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 0, 4095, (i == 19));
    chk("sat_bin0", int'(bs[0]), 65535);
    chk("wrap_bin0", int'(bw[0]), 16364);
    chk("model_wrap_bin0", mw[0], 16364);
    idle(2);

    // Illegal bin with last: no bin change, error set, window closes.
    pulses = 0;
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 40, 100, 1'b1);
    chk("illegal_err", int'(err_s), 1);
    chk("illegal_data_en", int'(den_s), 1);
    chk("illegal_bin0", int'(bs[0]), 0);
    idle(2);
    chk("illegal_err_sticky", int'(err_w), 1);
    chk("illegal_pulses", pulses, 1);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("illegal_err_cleared", int'(err_s), 0);

    // Abort mid-window, then a one-sample window.
    pulses = 0;
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 3, 50, 1'b0);
    chk("abort_bin3_before", int'(bs[3]), 50);
    step(1'b1, 1'b0, 0, 0, 1'b0);
    chk("abort_bin3_cleared", int'(bs[3]), 0);
    step(1'b0, 1'b1, 3, 1, 1'b1);
    chk("abort_bin3", int'(bs[3]), 1);
    idle(3);
    chk("abort_pulses", pulses, 1);

    // Reset in the middle of a window.
    pulses = 0;
    step(1'b1, 1'b0, 0, 0, 1'b0);
    step(1'b0, 1'b1, 7, 9, 1'b0);
    chk("rst_bin7_before", int'(bs[7]), 9);
    #2;
    ireset = 1'b0;
    model_clear();
    m_open = 1'b0;
    m_den = 1'b0;
    m_err = 1'b0;
    #1;
    chk("rst_bin7", int'(bs[7]), 0);
    chk("rst_wrap_bin7", int'(bw[7]), 0);
    chk("rst_busy", int'(busy_s), 0);
    repeat (2) @(posedge iclk);
    #1;
    ireset = 1'b1;
    idle(4);
    chk("rst_pulses", pulses, 0);

    // Samples while idle are dropped.
    step(1'b0, 1'b1, 2, 8, 1'b0);
    step(1'b0, 1'b1, 2, 8, 1'b1);
    chk("idle_bin2", int'(bs[2]), 0);
    idle(2);
    chk("idle_pulses", pulses, 0);

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
